// File: rtl/perf_monitor.sv
// Performance monitor: NUM_EVT event counters plus a run-cycle counter, snapshot shadows, sticky saturation flags.
// Latency: counters update on the edge that closes a RUN cycle; snapshots land at the snap_i edge, snap_vld_o one cycle later.
// Backpressure: none; events are sampled every clock and reads are combinational from the shadow registers.
//
// Ports:
//   clk_i, rst_i (async, active-low)  clock and reset
//   start_i    level run enable (1 = count, 0 = pause)
//   clear_i    synchronous clear of counters, shadows, flags and state
//   evt_i      event strobes, one per channel
//   mode_i     per channel: 0 = count high cycles, 1 = count rising edges
//   snap_i     copy live counters into the shadow registers
//   rd_sel_i   shadow select: channel index, NUM_EVT = cycle count, others read 0
//   rd_data_o  selected shadow value
//   cycle_o    live run-cycle counter
//   ovf_o      sticky per-channel saturation flags
//   done_o     high while the run-cycle limit has been reached
//   snap_vld_o pulse on the cycle after a shadow update
module perf_monitor #(
  parameter int NUM_EVT    = 4,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 64
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               start_i,
  input  logic                               clear_i,
  input  logic [NUM_EVT-1:0]                 evt_i,
  input  logic [NUM_EVT-1:0]                 mode_i,
  input  logic                               snap_i,
  input  logic [$clog2(NUM_EVT+1)-1:0]       rd_sel_i,
  output logic [CNT_W-1:0]                   rd_data_o,
  output logic [CNT_W-1:0]                   cycle_o,
  output logic [NUM_EVT-1:0]                 ovf_o,
  output logic                               done_o,
  output logic                               snap_vld_o
);

  localparam int SEL_W = $clog2(NUM_EVT+1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CYC_LIMIT = CNT_W'(MAX_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cycle;
  logic [CNT_W-1:0]     r_cnt [NUM_EVT];
  logic [CNT_W-1:0]     r_sh_cnt [NUM_EVT];
  logic [CNT_W-1:0]     r_sh_cyc;
  logic [NUM_EVT-1:0]   r_ovf;
  logic [NUM_EVT-1:0]   r_evt_q;
  logic                 r_snap_vld;

  logic                 w_run;
  logic [CNT_W-1:0]     w_cyc_nxt;
  logic                 w_hit_limit;
  logic [NUM_EVT-1:0]   w_evt_hit;
  logic [NUM_EVT-1:0]   w_evt_inc;
  logic [CNT_W-1:0]     w_rd_data;

  assign w_run = (r_state == S_RUN);

  // Cycle counter saturates rather than wrapping (only reachable with MAX_CYCLES = 0).
  assign w_cyc_nxt = (w_run && (r_cycle != CNT_MAX)) ? r_cycle + CNT_W'(1) : r_cycle;

  // DONE is entered on the same edge the counter reaches the limit.
  assign w_hit_limit = (MAX_CYCLES != 0) && w_run && (w_cyc_nxt == CYC_LIMIT);

  // Mode 0 counts every high cycle; mode 1 only the first high cycle after a low sample.
  assign w_evt_hit = (evt_i & ~mode_i) | (evt_i & ~r_evt_q & mode_i);
  assign w_evt_inc = w_run ? w_evt_hit : '0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_hit_limit)   w_state_nxt = S_DONE;
        else if (!start_i) w_state_nxt = S_PAUSE;
      end
      S_PAUSE: if (start_i) w_state_nxt = S_RUN;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_cycle    <= '0;
      r_sh_cyc   <= '0;
      r_ovf      <= '0;
      r_evt_q    <= '0;
      r_snap_vld <= 1'b0;
      for (int k = 0; k < NUM_EVT; k++) begin
        r_cnt[k]    <= '0;
        r_sh_cnt[k] <= '0;
      end
    end else if (clear_i) begin
      // Clear wins over start_i and snap_i on the same edge.
      r_state    <= S_IDLE;
      r_cycle    <= '0;
      r_sh_cyc   <= '0;
      r_ovf      <= '0;
      r_evt_q    <= '0;
      r_snap_vld <= 1'b0;
      for (int k = 0; k < NUM_EVT; k++) begin
        r_cnt[k]    <= '0;
        r_sh_cnt[k] <= '0;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_cycle    <= w_cyc_nxt;
      r_evt_q    <= evt_i;
      r_snap_vld <= snap_i;
      for (int k = 0; k < NUM_EVT; k++) begin
        if (w_evt_inc[k]) begin
          if (r_cnt[k] == CNT_MAX) r_ovf[k] <= 1'b1;
          else                     r_cnt[k] <= r_cnt[k] + CNT_W'(1);
        end
      end
      // Shadows capture pre-edge values, in any state.
      if (snap_i) begin
        r_sh_cyc <= r_cycle;
        for (int k = 0; k < NUM_EVT; k++) begin
          r_sh_cnt[k] <= r_cnt[k];
        end
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < NUM_EVT; k++) begin
      if (rd_sel_i == SEL_W'(k)) w_rd_data = r_sh_cnt[k];
    end
    if (rd_sel_i == SEL_W'(NUM_EVT)) w_rd_data = r_sh_cyc;
  end

  assign rd_data_o  = w_rd_data;
  assign cycle_o    = r_cycle;
  assign ovf_o      = r_ovf;
  assign done_o     = (r_state == S_DONE);
  assign snap_vld_o = r_snap_vld;

endmodule
